hamming_nibble_packer: RTL and testbench
========================================

# hamming_nibble_packer

Downstream stage of the Hamming (8,4) decoder: it accepts one decoded 4-bit dataword per handshake, together with that word's 2-bit error flag. It packs consecutive nibble pairs into bytes and presents each byte on a valid/ready output with per-byte error summary bits. It also keeps saturating counts of corrected and uncorrectable codewords for status readout.

## Interface
Parameters:
- CNT_W, 8, width of each error counter
- LOW_FIRST, 1, 1: first accepted nibble is out_data[3:0]; 0: first nibble is out_data[7:4]

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  upstream nibble valid
- in_ready  out  1  packer can accept a nibble this cycle
- in_data  in  4  decoded dataword
- in_err  in  2  decoder error flag: 00 none, 01 single corrected, 10 double detected, 11 treated as 10
- flush  in  1  single-cycle pulse; emit a held half-byte padded with zeros
- out_valid  out  1  packed byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  packed byte
- out_corr  out  1  at least one nibble in byte was single-corrected
- out_uncorr  out  1  at least one nibble in byte was uncorrectable
- out_partial  out  1  byte was produced by flush (padded nibble is 0)
- clr_cnt  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_W  saturating count of accepted nibbles with in_err=01
- uncorr_cnt  out  CNT_W  saturating count of accepted nibbles with in_err=10/11

## Operation
- States: EMPTY (nothing held), HALF (one nibble held), FULL (byte held, out_valid=1).
- Input handshake fires when in_valid && in_ready. in_ready = (state != FULL) || out_ready (combinational). Output handshake fires when out_valid && out_ready.
- EMPTY + input handshake -> HALF; nibble and its flags are latched.
- HALF + input handshake -> FULL; byte is formed per LOW_FIRST. out_corr and out_uncorr are the OR of both nibbles' flags. out_partial=0.
- HALF + flush without input handshake -> FULL. The missing nibble is 0 and out_partial=1.
- HALF + flush with input handshake: the input completes the byte normally (out_partial=0) and flush is ignored.
- FULL + output handshake, no input handshake -> EMPTY.
- FULL + output handshake + input handshake -> HALF holding the new nibble. The next byte starts with no bubble.
- FULL without output handshake: hold all outputs stable. in_ready=0.
- flush in EMPTY or FULL: no effect.
- Counters: increment on every input handshake per in_err class and saturate at all-ones (no wrap). Flush-padded nibbles never count.
- clr_cnt has priority over a same-cycle increment: the counter becomes 0.
- rst (any state, including mid-byte): state=EMPTY and the held nibble is discarded.
  - Reset values: out_valid=0, out_data=0, out_corr=0, out_uncorr=0, out_partial=0, corr_cnt=0, uncorr_cnt=0.
  - in_ready=1 after reset (combinational from EMPTY).

## Timing
- All outputs except in_ready are registered.
- Latency: out_valid rises the cycle after the handshake of the second nibble, or after the flush cycle.
- Sustained throughput: one nibble per cycle, one byte per two cycles, with out_ready held high.
- Counters update the cycle after the input handshake.
- out_data, out_corr, out_uncorr and out_partial are stable while out_valid && !out_ready.

## Structure
- Shared package hamming_pkg:
  - error-flag constants ERR_NONE=2'b00, ERR_CORR=2'b01, ERR_DBL=2'b10.
  - packer state encoding: EMPTY, HALF, FULL.
- One sub-module, hamming_sat_counter (parameter W; ports: clk, rst, clr, inc, count), instantiated twice.

## Test plan
- Basic pack: LOW_FIRST=1, send 4'hA/00 then 4'h5/00 with out_ready=1 -> one cycle later out_data=8'h5A, out_corr=0, out_uncorr=0, out_partial=0; counters stay 0.
- Error summary: send 4'h3/01 then 4'hC/10 -> out_data=8'hC3, out_corr=1, out_uncorr=1; corr_cnt=1, uncorr_cnt=1. A nibble with in_err=11 increments uncorr_cnt.
- Backpressure: byte 8'h21 pending with out_ready=0 for 5 cycles -> in_ready=0, outputs held. Raise out_ready with in_valid=1 and 4'h7 -> byte consumed, state HALF, next byte completes with no bubble.
- Flush: one nibble 4'h9 held, pulse flush -> out_data=8'h09, out_partial=1. Flush in EMPTY -> out_valid stays 0.
- Saturation/clear: CNT_W=2, send 5 corrected nibbles -> corr_cnt=3. Assert clr_cnt with a simultaneous corrected nibble -> corr_cnt=0.
- Reset mid-byte: one nibble held, assert rst for 1 cycle -> EMPTY, out_valid=0. Next two nibbles 4'h1, 4'h2 -> out_data=8'h21.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming (8,4) decode path: decoder error-flag
// encodings and the nibble packer state encoding.
package hamming_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CORR = 2'b01;
  localparam logic [1:0] ERR_DBL  = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } pack_state_e;

endpackage

// File: rtl/hamming_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module hamming_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hamming_nibble_packer.sv
// Packs decoded Hamming nibbles into bytes with per-byte error summary bits
// and keeps saturating counts of corrected / uncorrectable codewords.
module hamming_nibble_packer
  import hamming_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  input  logic [1:0]       in_err,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_corr,
  output logic             out_uncorr,
  output logic             out_partial,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  pack_state_e r_state;
  logic [3:0]  r_hold_data;
  logic        r_hold_corr;
  logic        r_hold_unc;

  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_in_corr;
  logic        w_in_unc;

  function automatic logic [7:0] pack_byte(input logic [3:0] first,
                                           input logic [3:0] second);
    return LOW_FIRST ? {second, first} : {first, second};
  endfunction

  assign in_ready  = (r_state != FULL) || out_ready;
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;
  // 2'b11 is treated as a detected double error.
  assign w_in_corr = (in_err == ERR_CORR);
  assign w_in_unc  = in_err[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= EMPTY;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_corr    <= 1'b0;
      out_uncorr  <= 1'b0;
      out_partial <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_hs) r_state <= HALF;
        end
        HALF: begin
          if (w_in_hs) begin
            r_state     <= FULL;
            out_valid   <= 1'b1;
            out_data    <= pack_byte(r_hold_data, in_data);
            out_corr    <= r_hold_corr || w_in_corr;
            out_uncorr  <= r_hold_unc || w_in_unc;
            out_partial <= 1'b0;
          end else if (flush) begin
            r_state     <= FULL;
            out_valid   <= 1'b1;
            out_data    <= pack_byte(r_hold_data, 4'h0);
            out_corr    <= r_hold_corr;
            out_uncorr  <= r_hold_unc;
            out_partial <= 1'b1;
          end
        end
        FULL: begin
          // An input handshake here implies out_ready, so the byte leaves too.
          if (w_out_hs) begin
            out_valid <= 1'b0;
            r_state   <= w_in_hs ? HALF : EMPTY;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  // Held first nibble; loaded whenever a handshake starts a new byte.
  always_ff @(posedge clk) begin
    if (w_in_hs && (r_state != HALF)) begin
      r_hold_data <= in_data;
      r_hold_corr <= w_in_corr;
      r_hold_unc  <= w_in_unc;
    end
  end

  hamming_sat_counter #(.W(CNT_W)) u_corr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_in_hs && w_in_corr),
    .count (corr_cnt)
  );

  hamming_sat_counter #(.W(CNT_W)) u_uncorr_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_cnt),
    .inc   (w_in_hs && w_in_unc),
    .count (uncorr_cnt)
  );

endmodule

// File: tb/tb_hamming_nibble_packer.sv
// Scoreboard bench for hamming_nibble_packer: directed nibble sequences with
// hand-computed bytes queued as expectations, popped by an output monitor.
module tb_hamming_nibble_packer;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_data = '0;
  logic [1:0]       in_err = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [7:0]       out_data;
  logic             out_corr;
  logic             out_uncorr;
  logic             out_partial;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] corr_cnt;
  logic [CNT_W-1:0] uncorr_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // Expected byte record: {data, corr, uncorr, partial}
  logic [10:0] exp_q[$];

  hamming_nibble_packer #(.CNT_W(CNT_W), .LOW_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_err     (in_err),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_corr   (out_corr),
    .out_uncorr (out_uncorr),
    .out_partial(out_partial),
    .clr_cnt    (clr_cnt),
    .corr_cnt   (corr_cnt),
    .uncorr_cnt (uncorr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic c, input logic u, input logic p);
    exp_q.push_back({d, c, u, p});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one nibble and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send(input logic [3:0] d, input logic [1:0] e);
    int waited;
    in_valid = 1'b1;
    in_data  = d;
    in_err   = e;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", 32'(waited), 32'd0);
    tick();
    in_valid = 1'b0;
  endtask

  // Output monitor: every output handshake must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {21'd0, out_data, out_corr, out_uncorr, out_partial}, 32'hFFFF);
        else chk("out_byte", {21'd0, out_data, out_corr, out_uncorr, out_partial},
                 {21'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_flags", {29'd0, out_corr, out_uncorr, out_partial}, 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic pack
    expect_byte(8'h5A, 1'b0, 1'b0, 1'b0);
    send(4'hA, 2'b00);
    chk("basic_no_early_valid", 32'(out_valid), 32'd0);
    send(4'h5, 2'b00);
    chk("basic_latency", 32'(out_valid), 32'd1);
    tick(); tick();
    chk("basic_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("basic_uncorr_cnt", 32'(uncorr_cnt), 32'd0);

    // Error summary, including 2'b11 counted as uncorrectable
    expect_byte(8'hC3, 1'b1, 1'b1, 1'b0);
    send(4'h3, 2'b01);
    send(4'hC, 2'b10);
    tick();
    chk("err_corr_cnt", 32'(corr_cnt), 32'd1);
    chk("err_uncorr_cnt", 32'(uncorr_cnt), 32'd1);
    expect_byte(8'h0E, 1'b0, 1'b1, 1'b0);
    send(4'hE, 2'b11);
    send(4'h0, 2'b00);
    tick();
    chk("err11_uncorr_cnt", 32'(uncorr_cnt), 32'd2);
    chk("err11_corr_cnt", 32'(corr_cnt), 32'd1);

    // Backpressure, then consume-and-accept in the same cycle with no bubble
    out_ready = 1'b0;
    expect_byte(8'h21, 1'b0, 1'b0, 1'b0);
    send(4'h1, 2'b00);
    send(4'h2, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", {21'd0, out_data, out_corr, out_uncorr, out_partial},
          {21'd0, 8'h21, 3'b000});
      chk("bp_valid", 32'(out_valid), 32'd1);
    end
    tick();
    out_ready = 1'b1;
    expect_byte(8'h87, 1'b0, 1'b0, 1'b0);
    send(4'h7, 2'b00);
    chk("bp_half_after_swap", 32'(out_valid), 32'd0);
    send(4'h8, 2'b00);
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    tick();

    // Flush of a held nibble
    send(4'h9, 2'b00);
    expect_byte(8'h09, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_latency", 32'(out_valid), 32'd1);
    tick(); tick();
    // Flush while empty does nothing
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("flush_empty", 32'(out_valid), 32'd0);
    // Flush coinciding with the second nibble is ignored
    send(4'h4, 2'b00);
    expect_byte(8'h64, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    send(4'h6, 2'b01);
    flush = 1'b0;
    chk("flush_ignored_cnt", 32'(corr_cnt), 32'd2);
    tick(); tick();

    // Clear, saturation, clear priority over increment
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_corr", 32'(corr_cnt), 32'd0);
    chk("clr_uncorr", 32'(uncorr_cnt), 32'd0);
    expect_byte(8'h21, 1'b1, 1'b0, 1'b0);
    expect_byte(8'h43, 1'b1, 1'b0, 1'b0);
    expect_byte(8'h65, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) send(4'(i), 2'b01);
    chk("sat_corr", 32'(corr_cnt), 32'd3);
    clr_cnt = 1'b1;
    send(4'h6, 2'b01);
    clr_cnt = 1'b0;
    chk("clr_priority", 32'(corr_cnt), 32'd0);
    tick(); tick();

    // Reset mid-byte discards the held nibble
    send(4'h3, 2'b00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    expect_byte(8'h21, 1'b0, 1'b0, 1'b0);
    send(4'h1, 2'b00);
    send(4'h2, 2'b00);
    tick(); tick(); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
